// File: rtl/wf_capture.sv
// wf_capture: serial waveform receiver. Samples one bit per clock (LSB first),
// assembles WORD_W-bit words and stores DEPTH of them into a pattern memory
// that the host reads back through a combinational port.
module wf_capture #(
    parameter int WORD_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic              wf,
    output logic              busy,
    output logic              done,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_out,
    output logic [ADDR_W-1:0] word_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [ADDR_W-1:0]  addr;
    logic [WORD_W-1:0]  shift_reg;
    logic [WORD_W-1:0]  mem [DEPTH];
    logic [WORD_W-1:0]  full_word;
    logic               last_bit;

    assign last_bit = (bit_cnt == CNT_W'(WORD_W - 1));

    // Word as it will look once the current wf bit lands in position bit_cnt.
    always_comb begin
        // NOTE: assign a full default before the partial update so no latch is inferred.
        full_word          = shift_reg;
        full_word[bit_cnt] = wf;
    end

    // Capture FSM, counters, registered outputs and pattern memory.
    always_ff @(posedge clk) begin
        if (!clear) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            word_valid <= 1'b0;
            word_out   <= '0;
            word_addr  <= '0;
            bit_cnt    <= '0;
            addr       <= '0;
            shift_reg  <= '0;
            // NOTE: the memory is a register array so it can be cleared in one
            // cycle; a RAM macro could not honour this reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking throughout, so every branch sees pre-edge values.
            word_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_CAPTURE;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        addr    <= '0;
                    end
                end
                ST_CAPTURE: begin
                    shift_reg <= full_word;
                    bit_cnt   <= bit_cnt + 1'b1;
                    if (last_bit) begin
                        mem[addr]  <= full_word;
                        word_out   <= full_word;
                        word_addr  <= addr;
                        word_valid <= 1'b1;
                        if (addr == ADDR_W'(DEPTH - 1)) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state   <= ST_CAPTURE;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        bit_cnt <= '0;
                        addr    <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Host read port: old contents are returned while the same entry is written.
    assign rd_data = mem[rd_addr];

endmodule

// File: tb/tb_wf_capture.sv
// tb_wf_capture: self-checking bench for wf_capture. A behavioural model
// (bit count since the start edge, word array) predicts every cycle; directed
// sequences add constant expectations for the documented corner cases.
module tb_wf_capture;

    localparam int WORD_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              clear;
    logic              start;
    logic              wf;
    logic              busy;
    logic              done;
    logic              word_valid;
    logic [WORD_W-1:0] word_out;
    logic [ADDR_W-1:0] word_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [WORD_W-1:0] rd_data;

    wf_capture #(.WORD_W(WORD_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .clear      (clear),
        .start      (start),
        .wf         (wf),
        .busy       (busy),
        .done       (done),
        .word_valid (word_valid),
        .word_out   (word_out),
        .word_addr  (word_addr),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int pulses = 0;

    // Reference model state.
    bit      m_running;
    bit      m_done;
    int      m_k;
    int      m_acc;
    bit      m_wv;
    int      m_wo;
    int      m_wa;
    int      m_mem [DEPTH];

    typedef struct {
        logic [WORD_W-1:0] wf_word;
        logic [WORD_W-1:0] exp_word;
        logic [ADDR_W-1:0] exp_addr;
    } vec_t;

    vec_t full_tbl [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model one rising edge with the inputs that were present before it.
    task automatic model_edge(input logic c, input logic s, input logic w);
        if (!c) begin
            m_running = 0; m_done = 0; m_k = 0; m_acc = 0;
            m_wv = 0; m_wo = 0; m_wa = 0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        end else begin
            m_wv = 0;
            if (m_running) begin
                if (m_k % WORD_W == 0) m_acc = 0;
                m_acc = m_acc | (int'(w) << (m_k % WORD_W));
                if (m_k % WORD_W == WORD_W - 1) begin
                    m_mem[m_k / WORD_W] = m_acc;
                    m_wv = 1;
                    m_wo = m_acc;
                    m_wa = m_k / WORD_W;
                    if (m_k == WORD_W * DEPTH - 1) begin
                        m_running = 0;
                        m_done    = 1;
                    end
                end
                m_k++;
            end else if (s) begin
                m_running = 1;
                m_done    = 0;
                m_k       = 0;
            end
        end
    endtask

    // One clock edge: advance the model, then compare the DUT 1 time unit later.
    task automatic tick();
        logic c, s, w;
        c = clear; s = start; w = wf;
        @(posedge clk);
        #1;
        model_edge(c, s, w);
        if (word_valid === 1'b1) pulses++;
        check("busy", 32'(busy), 32'(m_running));
        check("done", 32'(done), 32'(m_done));
        check("word_valid", 32'(word_valid), 32'(m_wv));
        if (m_wv) begin
            check("word_out", 32'(word_out), 32'(m_wo));
            check("word_addr", 32'(word_addr), 32'(m_wa));
        end
        check("rd_data_model", 32'(rd_data), 32'(m_mem[rd_addr]));
    endtask

    task automatic send_word(input logic [WORD_W-1:0] w);
        for (int k = 0; k < WORD_W; k++) begin
            wf = w[k];
            tick();
        end
    endtask

    task automatic do_reset();
        clear = 1'b0;
        tick();
        clear = 1'b1;
    endtask

    task automatic check_mem_zero(input string name);
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = ADDR_W'(i);
            #1;
            check(name, 32'(rd_data), 32'h0);
        end
    endtask

    initial begin
        int cyc;
        clear   = 1'b0;
        start   = 1'b1;
        wf      = 1'b1;
        rd_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            full_tbl[i].wf_word  = WORD_W'(8'h11 * i);
            full_tbl[i].exp_word = WORD_W'(8'h11 * i);
            full_tbl[i].exp_addr = ADDR_W'(i);
        end

        // Reset held for two edges with start and wf high.
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_word_valid", 32'(word_valid), 32'h0);
        check("rst_word_out", 32'(word_out), 32'h0);
        check("rst_word_addr", 32'(word_addr), 32'h0);
        check_mem_zero("rst_mem");

        // Single word 0xA5 sent LSB first.
        clear = 1'b1;
        start = 1'b1;
        tick();
        start  = 1'b0;
        pulses = 0;
        send_word(8'hA5);
        check("single_pulses", 32'(pulses), 32'd1);
        check("single_word_valid", 32'(word_valid), 32'h1);
        check("single_word_out", 32'(word_out), 32'hA5);
        check("single_word_addr", 32'(word_addr), 32'h0);
        rd_addr = '0;
        #1;
        check("single_rd0", 32'(rd_data), 32'hA5);

        // Full run from the stimulus table, done exactly 128 edges after start.
        do_reset();
        start = 1'b1;
        tick();
        start  = 1'b0;
        pulses = 0;
        cyc    = 0;
        for (int n = 0; n < DEPTH; n++) begin
            for (int k = 0; k < WORD_W; k++) begin
                if (n == DEPTH - 1 && k == WORD_W - 1)
                    check("full_done_early", 32'(done), 32'h0);
                wf = full_tbl[n].wf_word[k];
                tick();
                cyc++;
            end
            check("full_wv", 32'(word_valid), 32'h1);
            check("full_word_out", 32'(word_out), 32'(full_tbl[n].exp_word));
            check("full_word_addr", 32'(word_addr), 32'(full_tbl[n].exp_addr));
        end
        check("full_cycles", 32'(cyc), 32'd128);
        check("full_done", 32'(done), 32'h1);
        check("full_busy", 32'(busy), 32'h0);
        check("full_pulses", 32'(pulses), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = ADDR_W'(i);
            #1;
            check("full_rd", 32'(rd_data), 32'(full_tbl[i].exp_word));
        end

        // Restart from DONE with an all-ones word; older entries survive.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_done", 32'(done), 32'h0);
        check("restart_busy", 32'(busy), 32'h1);
        send_word(8'hFF);
        rd_addr = '0;
        #1;
        check("restart_rd0", 32'(rd_data), 32'hFF);
        for (int i = 1; i < DEPTH; i++) begin
            rd_addr = ADDR_W'(i);
            #1;
            check("restart_rd_keep", 32'(rd_data), 32'(8'h11 * i));
        end
        do_reset();
        check_mem_zero("restart_clear_mem");

        // Random run with a start pulse at cycle 40 that must be ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 0;
        while (done !== 1'b1 && cyc < 200) begin
            start   = (cyc == 40);
            wf      = 1'($urandom);
            rd_addr = ADDR_W'($urandom);
            tick();
            cyc++;
        end
        start = 1'b0;
        check("busy_start_cycles", 32'(cyc), 32'd128);
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = ADDR_W'(i);
            #1;
            check("busy_start_rd", 32'(rd_data), 32'(m_mem[i]));
        end

        // Reset mid-capture at cycle 20, then a fresh random run from addr 0.
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wf = 1'($urandom);
            tick();
        end
        do_reset();
        check("mid_rst_busy", 32'(busy), 32'h0);
        check_mem_zero("mid_rst_mem");
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < WORD_W; k++) begin
            wf      = 1'($urandom);
            rd_addr = ADDR_W'($urandom);
            tick();
        end
        check("mid_rst_wv", 32'(word_valid), 32'h1);
        check("mid_rst_addr", 32'(word_addr), 32'h0);
        for (int i = WORD_W; i < WORD_W * DEPTH; i++) begin
            wf      = 1'($urandom);
            rd_addr = ADDR_W'($urandom);
            tick();
        end
        check("mid_rst_done", 32'(done), 32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = ADDR_W'(i);
            #1;
            check("mid_rst_rd", 32'(rd_data), 32'(m_mem[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
